// File: rtl/mem_port_arbiter.sv
// Two-port memory arbiter: shares one memory port between an instruction port
// and a data port. Data normally has priority, and a starvation counter
// guarantees the instruction port a slot after STARVE_LIM back-to-back data
// grants. Only one memory transaction is outstanding at a time.
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_LIM = 4
) (
  input  logic                clk_i,
  input  logic                rst_i,
  // instruction port
  input  logic                instr_req_i,
  input  logic                instr_we_i,
  input  logic [ADDR_W-1:0]   instr_addr_i,
  input  logic [DATA_W-1:0]   instr_wdata_i,
  input  logic [DATA_W/8-1:0] instr_strb_i,
  output logic                instr_gnt_o,
  output logic                instr_rvalid_o,
  output logic [DATA_W-1:0]   instr_rdata_o,
  // data port
  input  logic                data_req_i,
  input  logic                data_we_i,
  input  logic [ADDR_W-1:0]   data_addr_i,
  input  logic [DATA_W-1:0]   data_wdata_i,
  input  logic [DATA_W/8-1:0] data_strb_i,
  output logic                data_gnt_o,
  output logic                data_rvalid_o,
  output logic [DATA_W-1:0]   data_rdata_o,
  // memory side
  output logic                mem_req_o,
  output logic                mem_we_o,
  output logic [ADDR_W-1:0]   mem_addr_o,
  output logic [DATA_W-1:0]   mem_wdata_o,
  output logic [DATA_W/8-1:0] mem_strb_o,
  input  logic                mem_gnt_i,
  input  logic                mem_rvalid_i,
  input  logic [DATA_W-1:0]   mem_rdata_i,
  // sticky protocol error
  output logic                err_o
);

  localparam logic [3:0] LIM = 4'(STARVE_LIM);

  typedef enum logic {IDLE, WAIT_RESP} state_t;

  state_t     state;
  logic       locked;
  logic       lock_instr;
  logic       owner_instr;
  logic [3:0] starve_cnt;
  logic       err_q;

  logic       sel_instr;
  logic       req_pending;
  logic       grant;
  logic       resp;

  // Pick the port that owns the memory request this cycle; a pending
  // ungranted request keeps its owner so the memory sees stable fields.
  always_comb begin
    sel_instr = 1'b0;
    if (locked)
      sel_instr = lock_instr;
    else if (instr_req_i && (starve_cnt == LIM))
      sel_instr = 1'b1;
    else if (data_req_i)
      sel_instr = 1'b0;
    else if (instr_req_i)
      sel_instr = 1'b1;
  end

  // Handshake qualifiers; reset forces every strobe low immediately.
  always_comb begin
    req_pending = (state == IDLE) && !rst_i && (locked || instr_req_i || data_req_i);
    grant       = req_pending && mem_gnt_i;
    resp        = (state == WAIT_RESP) && !rst_i && mem_rvalid_i;
  end

  // Drive memory fields from the selected owner and route grant/response back.
  always_comb begin
    mem_req_o      = req_pending;
    mem_we_o       = sel_instr ? instr_we_i    : data_we_i;
    mem_addr_o     = sel_instr ? instr_addr_i  : data_addr_i;
    mem_wdata_o    = sel_instr ? instr_wdata_i : data_wdata_i;
    mem_strb_o     = sel_instr ? instr_strb_i  : data_strb_i;
    instr_gnt_o    = grant && sel_instr;
    data_gnt_o     = grant && !sel_instr;
    instr_rvalid_o = resp && owner_instr;
    data_rvalid_o  = resp && !owner_instr;
    instr_rdata_o  = (resp && owner_instr)  ? mem_rdata_i : '0;
    data_rdata_o   = (resp && !owner_instr) ? mem_rdata_i : '0;
    err_o          = err_q;
  end

  // Arbitration FSM with owner lock, starvation counter and sticky error flag.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= IDLE;
      locked      <= 1'b0;
      lock_instr  <= 1'b0;
      owner_instr <= 1'b0;
      starve_cnt  <= 4'd0;
      err_q       <= 1'b0;
    end else begin
      if (((state == IDLE) && mem_rvalid_i) || (mem_gnt_i && !req_pending))
        err_q <= 1'b1;
      case (state)
        IDLE: begin
          if (grant) begin
            state       <= WAIT_RESP;
            owner_instr <= sel_instr;
            locked      <= 1'b0;
            if (sel_instr || !instr_req_i)
              starve_cnt <= 4'd0;
            else if (starve_cnt < LIM)
              starve_cnt <= starve_cnt + 4'd1;
          end else if (req_pending) begin
            locked     <= 1'b1;
            lock_instr <= sel_instr;
          end
        end
        WAIT_RESP: begin
          if (mem_rvalid_i)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed testbench for mem_port_arbiter: inputs change on the falling edge
// and outputs are checked 1 ns later, away from the rising edge.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_req, instr_we, instr_gnt, instr_rvalid;
  logic [31:0] instr_addr, instr_wdata, instr_rdata;
  logic [3:0]  instr_strb;
  logic        data_req, data_we, data_gnt, data_rvalid;
  logic [31:0] data_addr, data_wdata, data_rdata;
  logic [3:0]  data_strb;
  logic        mem_req, mem_we, mem_gnt, mem_rvalid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_strb;
  logic        err;

  int n_cmp = 0;
  int n_err = 0;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIM(4)) dut (
    .clk_i(clk), .rst_i(rst),
    .instr_req_i(instr_req), .instr_we_i(instr_we), .instr_addr_i(instr_addr),
    .instr_wdata_i(instr_wdata), .instr_strb_i(instr_strb),
    .instr_gnt_o(instr_gnt), .instr_rvalid_o(instr_rvalid), .instr_rdata_o(instr_rdata),
    .data_req_i(data_req), .data_we_i(data_we), .data_addr_i(data_addr),
    .data_wdata_i(data_wdata), .data_strb_i(data_strb),
    .data_gnt_o(data_gnt), .data_rvalid_o(data_rvalid), .data_rdata_o(data_rdata),
    .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .mem_strb_o(mem_strb),
    .mem_gnt_i(mem_gnt), .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata),
    .err_o(err)
  );

  // Free-running 10 ns clock.
  always #5 clk = ~clk;

  task automatic clear_inputs;
    instr_req = 0; instr_we = 0; instr_addr = 32'h0; instr_wdata = 32'h0; instr_strb = 4'h0;
    data_req = 0; data_we = 0; data_addr = 32'h0; data_wdata = 32'h0; data_strb = 4'h0;
    mem_gnt = 0; mem_rvalid = 0; mem_rdata = 32'h0;
  endtask

  task automatic pulse_reset;
    #2 rst = 1;
    @(negedge clk);
    rst = 0;
  endtask

  task automatic test_reset;
    clear_inputs();
    rst = 1;
    instr_req = 1; data_req = 1; mem_gnt = 1; mem_rvalid = 1;
    #1;
    n_cmp++;
    if ({mem_req, instr_gnt, data_gnt, instr_rvalid, data_rvalid} !== 5'b0) begin
      n_err++;
      $display("[TB] FAIL reset_strobes: got %b required 00000",
               {mem_req, instr_gnt, data_gnt, instr_rvalid, data_rvalid});
    end
    n_cmp++;
    if (err !== 1'b0) begin n_err++; $display("[TB] FAIL reset_err: got %b required 0", err); end
    @(negedge clk);
    clear_inputs();
    @(negedge clk);
    rst = 0;
  endtask

  task automatic test_single_read;
    @(negedge clk);
    instr_req = 1; instr_addr = 32'h80; mem_gnt = 1;
    #1;
    n_cmp++;
    if ({mem_req, instr_gnt, data_gnt} !== 3'b110) begin
      n_err++; $display("[TB] FAIL read_grant: req/igнт/dgnt got %b required 110", {mem_req, instr_gnt, data_gnt});
    end
    n_cmp++;
    if (mem_addr !== 32'h80) begin n_err++; $display("[TB] FAIL read_addr: got %h required 00000080", mem_addr); end
    @(negedge clk);
    instr_req = 0; mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'hDEADBEEF;
    #1;
    n_cmp++;
    if ({mem_req, instr_gnt, instr_rvalid, data_rvalid} !== 4'b0010) begin
      n_err++; $display("[TB] FAIL read_resp_flags: got %b required 0010", {mem_req, instr_gnt, instr_rvalid, data_rvalid});
    end
    n_cmp++;
    if (instr_rdata !== 32'hDEADBEEF) begin n_err++; $display("[TB] FAIL read_rdata: got %h required deadbeef", instr_rdata); end
    n_cmp++;
    if (data_rdata !== 32'h0) begin n_err++; $display("[TB] FAIL read_other_rdata: got %h required 00000000", data_rdata); end
    @(negedge clk);
    clear_inputs();
    #1;
    n_cmp++;
    if ({instr_rvalid, err} !== 2'b00) begin n_err++; $display("[TB] FAIL read_after: rvalid/err got %b required 00", {instr_rvalid, err}); end
  endtask

  task automatic test_write;
    @(negedge clk);
    data_req = 1; data_we = 1; data_addr = 32'h0; data_wdata = 32'h1; data_strb = 4'hF;
    instr_addr = 32'h55; instr_wdata = 32'h99; mem_gnt = 1;
    #1;
    n_cmp++;
    if ({mem_req, mem_we, data_gnt, instr_gnt} !== 4'b1110) begin
      n_err++; $display("[TB] FAIL write_grant: req/we/dgnt/ignt got %b required 1110", {mem_req, mem_we, data_gnt, instr_gnt});
    end
    n_cmp++;
    if ({mem_addr, mem_wdata, mem_strb} !== {32'h0, 32'h1, 4'hF}) begin
      n_err++; $display("[TB] FAIL write_fields: addr %h wdata %h strb %h required 0 1 f", mem_addr, mem_wdata, mem_strb);
    end
    @(negedge clk);
    clear_inputs();
    #1;
    n_cmp++;
    if ({mem_req, data_rvalid} !== 2'b00) begin n_err++; $display("[TB] FAIL write_wait: req/rvalid got %b required 00", {mem_req, data_rvalid}); end
    @(negedge clk);
    mem_rvalid = 1;
    #1;
    n_cmp++;
    if ({data_rvalid, instr_rvalid} !== 2'b10) begin n_err++; $display("[TB] FAIL write_resp: d/i rvalid got %b required 10", {data_rvalid, instr_rvalid}); end
    @(negedge clk);
    clear_inputs();
  endtask

  task automatic test_lock;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      instr_req = 1; instr_addr = 32'h100; data_addr = 32'h200;
      data_req = (c >= 2);
      mem_gnt = (c == 4);
      #1;
      n_cmp++;
      if (mem_addr !== 32'h100) begin n_err++; $display("[TB] FAIL lock_addr c%0d: got %h required 00000100", c, mem_addr); end
      n_cmp++;
      if ({mem_req, instr_gnt, data_gnt} !== {1'b1, (c == 4), 1'b0}) begin
        n_err++; $display("[TB] FAIL lock_gnt c%0d: req/ignt/dgnt got %b required %b", c, {mem_req, instr_gnt, data_gnt}, {1'b1, (c == 4), 1'b0});
      end
    end
    @(negedge clk);
    clear_inputs();
    mem_rvalid = 1; mem_rdata = 32'h0BAD_F00D;
    #1;
    n_cmp++;
    if ({instr_rvalid, data_rvalid, instr_rdata} !== {2'b10, 32'h0BAD_F00D}) begin
      n_err++; $display("[TB] FAIL lock_resp: rvalid %b%b rdata %h required 10 0badf00d", instr_rvalid, data_rvalid, instr_rdata);
    end
    @(negedge clk);
    clear_inputs();
  endtask

  task automatic test_starve;
    logic exp_i;
    for (int i = 0; i < 10; i++) begin
      exp_i = (i == 4) || (i == 9);
      @(negedge clk);
      instr_req = 1; data_req = 1; instr_addr = 32'hA0; data_addr = 32'hB0;
      mem_gnt = 1; mem_rvalid = 0;
      #1;
      n_cmp++;
      if ({instr_gnt, data_gnt, mem_addr} !== {exp_i, !exp_i, (exp_i ? 32'hA0 : 32'hB0)}) begin
        n_err++; $display("[TB] FAIL starve_grant #%0d: ignt %b dgnt %b addr %h required ignt %b", i, instr_gnt, data_gnt, mem_addr, exp_i);
      end
      @(negedge clk);
      mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'(i);
      #1;
      n_cmp++;
      if ({instr_rvalid, data_rvalid, mem_req} !== {exp_i, !exp_i, 1'b0}) begin
        n_err++; $display("[TB] FAIL starve_resp #%0d: irv %b drv %b req %b required irv %b", i, instr_rvalid, data_rvalid, mem_req, exp_i);
      end
    end
    @(negedge clk);
    clear_inputs();
  endtask

  task automatic test_err_rvalid;
    @(negedge clk);
    mem_rvalid = 1; mem_rdata = 32'h1234;
    #1;
    n_cmp++;
    if ({instr_rvalid, data_rvalid, err} !== 3'b000) begin
      n_err++; $display("[TB] FAIL stray_rvalid_now: irv/drv/err got %b required 000", {instr_rvalid, data_rvalid, err});
    end
    @(negedge clk);
    mem_rvalid = 0;
    #1;
    n_cmp++;
    if (err !== 1'b1) begin n_err++; $display("[TB] FAIL stray_rvalid_err: got %b required 1", err); end
    repeat (3) @(negedge clk);
    #1;
    n_cmp++;
    if (err !== 1'b1) begin n_err++; $display("[TB] FAIL err_sticky: got %b required 1", err); end
    rst = 1;
    #1;
    n_cmp++;
    if (err !== 1'b0) begin n_err++; $display("[TB] FAIL err_reset: got %b required 0", err); end
    @(negedge clk);
    rst = 0;
  endtask

  task automatic test_err_gnt;
    @(negedge clk);
    mem_gnt = 1;
    #1;
    n_cmp++;
    if ({instr_gnt, data_gnt} !== 2'b00) begin n_err++; $display("[TB] FAIL spurious_gnt_now: got %b required 00", {instr_gnt, data_gnt}); end
    @(negedge clk);
    mem_gnt = 0;
    #1;
    n_cmp++;
    if (err !== 1'b1) begin n_err++; $display("[TB] FAIL spurious_gnt_err: got %b required 1", err); end
    pulse_reset();
  endtask

  task automatic test_reset_in_wait;
    @(negedge clk);
    data_req = 1; data_addr = 32'h40; mem_gnt = 1;
    #1;
    n_cmp++;
    if (data_gnt !== 1'b1) begin n_err++; $display("[TB] FAIL rstwait_grant: got %b required 1", data_gnt); end
    @(negedge clk);
    data_req = 0; mem_gnt = 0;
    #2;
    rst = 1; data_req = 1; mem_rvalid = 1;
    #1;
    n_cmp++;
    if ({mem_req, instr_gnt, data_gnt, instr_rvalid, data_rvalid} !== 5'b0) begin
      n_err++; $display("[TB] FAIL rstwait_outputs: got %b required 00000", {mem_req, instr_gnt, data_gnt, instr_rvalid, data_rvalid});
    end
    @(negedge clk);
    rst = 0; data_req = 0; mem_rvalid = 1;
    #1;
    n_cmp++;
    if ({data_rvalid, instr_rvalid} !== 2'b00) begin n_err++; $display("[TB] FAIL rstwait_stray: rvalid got %b required 00", {data_rvalid, instr_rvalid}); end
    @(negedge clk);
    mem_rvalid = 0;
    #1;
    n_cmp++;
    if (err !== 1'b1) begin n_err++; $display("[TB] FAIL rstwait_err: got %b required 1", err); end
    pulse_reset();
    @(negedge clk);
    data_req = 1; data_addr = 32'h44; mem_gnt = 1;
    #1;
    n_cmp++;
    if ({data_gnt, mem_addr} !== {1'b1, 32'h44}) begin
      n_err++; $display("[TB] FAIL rstwait_regrant: gnt %b addr %h required 1 00000044", data_gnt, mem_addr);
    end
    @(negedge clk);
    data_req = 0; mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'h5678;
    #1;
    n_cmp++;
    if ({data_rvalid, data_rdata, err} !== {1'b1, 32'h5678, 1'b0}) begin
      n_err++; $display("[TB] FAIL rstwait_reresp: rvalid %b rdata %h err %b required 1 00005678 0", data_rvalid, data_rdata, err);
    end
    @(negedge clk);
    clear_inputs();
  endtask

  // Run every scenario in order, then report.
  initial begin
    test_reset();
    test_single_read();
    test_write();
    test_lock();
    test_starve();
    test_err_rvalid();
    test_err_gnt();
    test_reset_in_wait();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001: Parameter ADDR_W, default 32, address width of all ports.
REQ-002: Parameter DATA_W, default 32, data width; strobe width is DATA_W/8.
REQ-003: Parameter STARVE_LIM, default 4, maximum consecutive data grants while the instr port waits (range 1..15).
REQ-004: clk_i  in  1  sole clock; all state updates on the rising edge.
REQ-005: rst_i  in  1  reset, asynchronous and active-high.
REQ-006: instr_req_i, instr_we_i  in  1 each  instr-port request and write enable.
REQ-007: instr_addr_i  in  ADDR_W; instr_wdata_i  in  DATA_W; instr_strb_i  in  DATA_W/8.
REQ-008: instr_gnt_o, instr_rvalid_o  out  1 each; instr_rdata_o  out  DATA_W.
REQ-009: data_* ports SHALL mirror REQ-006..REQ-008 exactly, with the prefix data_.
REQ-010: mem_req_o, mem_we_o  out  1; mem_addr_o  out  ADDR_W; mem_wdata_o  out  DATA_W; mem_strb_o  out  DATA_W/8.
REQ-011: mem_gnt_i, mem_rvalid_i  in  1; mem_rdata_i  in  DATA_W.
REQ-012: err_o  out  1  sticky protocol-error flag.

Function
REQ-013: FSM states SHALL be IDLE and WAIT_RESP, with exactly one outstanding memory transaction at any time.
REQ-014: IDLE: if either req_i is high, mem_req_o=1 and the mem_* fields SHALL come combinationally from the selected owner.
REQ-015: Selection in IDLE SHALL give priority to data, except that instr wins when starve_cnt==STARVE_LIM and instr_req_i=1.
REQ-016: Once mem_req_o is high without mem_gnt_i, the owner SHALL be locked and held unchanged until granted, even if the other port raises req.
REQ-017: On mem_gnt_i=1 in IDLE, the owner's gnt_o SHALL be 1 in the same cycle, the other gnt_o 0, and the owner SHALL be registered; next state is WAIT_RESP.
REQ-018: In WAIT_RESP, mem_req_o and both gnt_o SHALL be 0.
REQ-019: On mem_rvalid_i in WAIT_RESP, the owner's rvalid_o=1 and rdata_o=mem_rdata_i (same cycle, combinational), and the other rvalid_o=0; next state is IDLE.
REQ-020: Every transaction (read or write) SHALL receive exactly one mem_rvalid_i; minimum issue interval is therefore 2 cycles (grant, then rvalid at least 1 cycle later).
REQ-021: starve_cnt (4 bits) SHALL be cleared on an instr grant or on a data grant with instr_req_i=0, incremented on a data grant with instr_req_i=1, and saturate at STARVE_LIM.
REQ-022: A non-owner rdata_o SHALL be 0, and rvalid_o SHALL never be asserted outside WAIT_RESP.
REQ-023: mem_rvalid_i=1 in IDLE SHALL be ignored and SHALL set err_o; mem_gnt_i=1 with mem_req_o=0 SHALL also set err_o.
REQ-024: err_o SHALL stay 1 until reset.
REQ-025: A port dropping req_i before grant in the unlocked state SHALL simply lose arbitration, with no state change.

Reset
REQ-026: While rst_i=1: state=IDLE, no lock, starve_cnt=0, err_o=0, and all gnt_o/rvalid_o/mem_req_o SHALL be 0 asynchronously.
REQ-027: Reset asserted in WAIT_RESP SHALL abandon the transaction, and a later stray mem_rvalid_i SHALL flag err_o.
REQ-028: The first arbitration SHALL occur in the first rising edge after rst_i deasserts.

Verification
REQ-029: Only instr_req_i=1, addr 0x80, mem_gnt_i immediate, rvalid next cycle with rdata 0xDEADBEEF -> instr_gnt_o 1 cycle, then instr_rvalid_o=1 and instr_rdata_o=0xDEADBEEF; data_rvalid_o=0.
REQ-030: Both req held continuously, STARVE_LIM=4 -> grant order D,D,D,D,I,D,D,D,D,I and starve_cnt never exceeds 4.
REQ-031: instr requests alone and mem_gnt_i is held low 3 cycles; data_req_i rises in cycle 2 -> grant still goes to instr, with mem_addr_o stable all 4 cycles.
REQ-032: Data write, we=1, addr 0x0, wdata 0x1, strb 0xF -> mem_we_o=1 and mem_addr_o=0x0 with the same wdata and strb; data_rvalid_o follows mem_rvalid_i.
REQ-033: mem_rvalid_i pulsed in IDLE -> err_o=1 next cycle, held until rst_i, with no rvalid_o asserted.
REQ-034: rst_i pulsed in WAIT_RESP -> outputs are 0 immediately and state=IDLE; a subsequent request is granted normally.
